dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory between the CPU load/store path and a debug/dump port, which the bench uses to read memory without hierarchical peeks.
- Handles the CPU's sub-word accesses: generates byte enables and write-data replication for sb/sh/sw, and lane extraction with sign/zero extension for lb/lbu/lh/lhu/lw.
- Memory is little-endian and word-organised, with a 1-cycle synchronous read.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU load/store port, the debug/dump port and the single-port
// data memory port that dmem_arbiter sits between.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic              cpu_sext;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_ack;
  logic [31:0]       dbg_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one word-wide synchronous RAM between the CPU
// load/store path (with sub-word lanes) and a debug word port, with anti-starvation.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  starve_reg, starve_next;

  logic              op_dbg_reg, op_dbg_next;
  logic              op_we_reg, op_we_next;
  logic [1:0]        op_size_reg, op_size_next;
  logic              op_sext_reg, op_sext_next;
  logic [ADDR_W-1:0] op_addr_reg, op_addr_next;
  logic [31:0]       op_wdata_reg, op_wdata_next;

  logic              cpu_ack_reg, cpu_ack_next;
  logic              cpu_err_reg, cpu_err_next;
  logic [31:0]       cpu_rdata_reg, cpu_rdata_next;
  logic              dbg_ack_reg, dbg_ack_next;
  logic [31:0]       dbg_rdata_reg, dbg_rdata_next;

  logic              grant_dbg, grant_cpu;
  logic              cpu_illegal;
  logic [7:0]        rd_lane [4];
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ext_data;
  logic [3:0]        st_we;
  logic [31:0]       st_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = bus.mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Debug only jumps the queue once the CPU has won STARVE_MAX times in a row over it.
  assign grant_dbg = bus.dbg_req && (!bus.cpu_req || (starve_reg == STARVE_LIM));
  assign grant_cpu = bus.cpu_req && !grant_dbg;

  always_comb begin
    cpu_illegal = 1'b0;
    case (bus.cpu_size)
      2'b00:   cpu_illegal = 1'b0;
      2'b01:   cpu_illegal = bus.cpu_addr[0];
      2'b10:   cpu_illegal = |bus.cpu_addr[1:0];
      default: cpu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    byte_v   = rd_lane[op_addr_reg[1:0]];
    half_v   = op_addr_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ext_data = bus.mem_rdata;
    if (!op_dbg_reg) begin
      case (op_size_reg)
        2'b00:   ext_data = {{24{op_sext_reg & byte_v[7]}}, byte_v};
        2'b01:   ext_data = {{16{op_sext_reg & half_v[15]}}, half_v};
        default: ext_data = bus.mem_rdata;
      endcase
    end
  end

  always_comb begin
    st_we    = 4'b1111;
    st_wdata = op_wdata_reg;
    if (!op_dbg_reg) begin
      case (op_size_reg)
        2'b00: begin
          st_we    = 4'b0001 << op_addr_reg[1:0];
          st_wdata = {4{op_wdata_reg[7:0]}};
        end
        2'b01: begin
          st_we    = op_addr_reg[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{op_wdata_reg[15:0]}};
        end
        default: begin
          st_we    = 4'b1111;
          st_wdata = op_wdata_reg;
        end
      endcase
    end
  end

  assign bus.mem_en    = (state_reg == ISSUE);
  assign bus.mem_we    = ((state_reg == ISSUE) && op_we_reg) ? st_we : 4'b0000;
  assign bus.mem_addr  = op_addr_reg[ADDR_W-1:2];
  assign bus.mem_wdata = st_wdata;

  assign bus.cpu_ack   = cpu_ack_reg;
  assign bus.cpu_err   = cpu_err_reg;
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.dbg_ack   = dbg_ack_reg;
  assign bus.dbg_rdata = dbg_rdata_reg;

  // Acks are raised on the transition into DONE so they are registered yet land in DONE.
  always_comb begin
    state_next     = state_reg;
    starve_next    = starve_reg;
    op_dbg_next    = op_dbg_reg;
    op_we_next     = op_we_reg;
    op_size_next   = op_size_reg;
    op_sext_next   = op_sext_reg;
    op_addr_next   = op_addr_reg;
    op_wdata_next  = op_wdata_reg;
    cpu_ack_next   = 1'b0;
    cpu_err_next   = 1'b0;
    cpu_rdata_next = cpu_rdata_reg;
    dbg_ack_next   = 1'b0;
    dbg_rdata_next = dbg_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_dbg) begin
          op_dbg_next   = 1'b1;
          op_we_next    = bus.dbg_we;
          op_size_next  = 2'b10;
          op_sext_next  = 1'b0;
          op_addr_next  = bus.dbg_addr;
          op_wdata_next = bus.dbg_wdata;
          starve_next   = '0;
          state_next    = ISSUE;
        end else if (grant_cpu) begin
          op_dbg_next   = 1'b0;
          op_we_next    = bus.cpu_we;
          op_size_next  = bus.cpu_size;
          op_sext_next  = bus.cpu_sext;
          op_addr_next  = bus.cpu_addr;
          op_wdata_next = bus.cpu_wdata;
          if (bus.dbg_req && (starve_reg != STARVE_LIM)) begin
            starve_next = starve_reg + CNT_W'(1);
          end
          if (cpu_illegal) begin
            cpu_ack_next = 1'b1;
            cpu_err_next = 1'b1;
            state_next   = DONE;
          end else begin
            state_next   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_we_reg) begin
          cpu_ack_next = !op_dbg_reg;
          dbg_ack_next = op_dbg_reg;
          state_next   = DONE;
        end else begin
          state_next   = RDWAIT;
        end
      end
      RDWAIT: begin
        cpu_ack_next = !op_dbg_reg;
        dbg_ack_next = op_dbg_reg;
        if (op_dbg_reg) begin
          dbg_rdata_next = bus.mem_rdata;
        end else begin
          cpu_rdata_next = ext_data;
        end
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      op_dbg_reg    <= 1'b0;
      op_we_reg     <= 1'b0;
      op_size_reg   <= 2'b00;
      op_sext_reg   <= 1'b0;
      op_addr_reg   <= '0;
      op_wdata_reg  <= '0;
      cpu_ack_reg   <= 1'b0;
      cpu_err_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      dbg_ack_reg   <= 1'b0;
      dbg_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      op_dbg_reg    <= op_dbg_next;
      op_we_reg     <= op_we_next;
      op_size_reg   <= op_size_next;
      op_sext_reg   <= op_sext_next;
      op_addr_reg   <= op_addr_next;
      op_wdata_reg  <= op_wdata_next;
      cpu_ack_reg   <= cpu_ack_next;
      cpu_err_reg   <= cpu_err_next;
      cpu_rdata_reg <= cpu_rdata_next;
      dbg_ack_reg   <= dbg_ack_next;
      dbg_rdata_reg <= dbg_rdata_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-array reference memory predicts
// load results, store lanes and ack latencies for directed and random traffic.
module tb_dmem_arbiter;

  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word RAM with one-cycle synchronous read.
  logic [31:0] mem_arr [1024];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we == 4'b0000) begin
        bus.mem_rdata <= mem_arr[bus.mem_addr];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (bus.mem_we[i]) mem_arr[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Reference model: plain little-endian byte memory.
  logic [7:0] ref_mem [4096];

  function automatic logic ref_err(input logic [1:0] size, input logic [11:0] addr);
    int a = int'(addr);
    return (size == 2'b11) || (size == 2'b01 && a % 2 != 0) || (size == 2'b10 && a % 4 != 0);
  endfunction

  function automatic void ref_store(input logic [1:0] size, input logic [11:0] addr, input logic [31:0] w);
    int n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[addr + 12'(i)] = w[8*i +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sext, input logic [11:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    b = ref_mem[addr];
    h = {ref_mem[addr + 12'd1], ref_mem[addr]};
    case (size)
      2'b00:   return sext ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sext ? {{16{h[15]}}, h} : {16'h0, h};
      default: return {ref_mem[addr + 12'd3], ref_mem[addr + 12'd2], h};
    endcase
  endfunction

  function automatic logic [3:0] exp_we(input logic [1:0] size, input logic [11:0] addr);
    int a = int'(addr) % 4;
    if (size == 2'b00) return 4'(1 << a);
    if (size == 2'b01) return (a >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'b00) return {4{w[7:0]}};
    if (size == 2'b01) return {2{w[15:0]}};
    return w;
  endfunction

  // One CPU transaction from an IDLE cycle; fields are scrambled right after the sample.
  task automatic do_cpu(input logic we, input logic [1:0] size, input logic sext,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int en_cnt, output logic [3:0] we_seen,
                        output logic [9:0] addr_seen, output logic [31:0] wdata_seen);
    bus.cpu_we = we; bus.cpu_size = size; bus.cpu_sext = sext;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    lat = -1; en_cnt = 0; we_seen = '0; addr_seen = '0; wdata_seen = '0; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.cpu_we = 1'($urandom); bus.cpu_size = 2'($urandom); bus.cpu_sext = 1'($urandom);
        bus.cpu_addr = 12'($urandom); bus.cpu_wdata = $urandom;
      end
      if (bus.mem_en) begin
        en_cnt++; we_seen = bus.mem_we; addr_seen = bus.mem_addr; wdata_seen = bus.mem_wdata;
      end
      if (bus.cpu_ack) begin
        lat = c; rdata = bus.cpu_rdata; err = bus.cpu_err;
        break;
      end
    end
    if (we && !ref_err(size, addr)) ref_store(size, addr, wdata);
    bus.cpu_req = 1'b0;
    $display("cpu %s size=%0d sext=%0d addr=0x%03h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0d",
             we ? "st" : "ld", size, sext, addr, wdata, lat, rdata, err);
    @(posedge clk); #1;
  endtask

  task automatic do_dbg(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output int en_cnt,
                        output logic [3:0] we_seen, output logic [9:0] addr_seen,
                        output logic [31:0] wdata_seen);
    bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_req = 1'b1;
    lat = -1; en_cnt = 0; we_seen = '0; addr_seen = '0; wdata_seen = '0; rdata = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.dbg_we = 1'($urandom); bus.dbg_addr = 12'($urandom); bus.dbg_wdata = $urandom;
      end
      if (bus.mem_en) begin
        en_cnt++; we_seen = bus.mem_we; addr_seen = bus.mem_addr; wdata_seen = bus.mem_wdata;
      end
      if (bus.dbg_ack) begin
        lat = c; rdata = bus.dbg_rdata;
        break;
      end
    end
    if (we) ref_store(2'b10, addr & 12'hFFC, wdata);
    bus.dbg_req = 1'b0;
    $display("dbg %s addr=0x%03h wdata=0x%08h -> lat=%0d rdata=0x%08h",
             we ? "wr" : "rd", addr, wdata, lat, rdata);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b want 0", bus.cpu_ack); end
    checks++; if (bus.cpu_err !== 1'b0) begin errors++; $display("FAIL reset_cpu_err: got %b want 0", bus.cpu_err); end
    checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", bus.cpu_rdata); end
    checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_dbg_ack: got %b want 0", bus.dbg_ack); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_dbg_rdata: got %h want 0", bus.dbg_rdata); end
    checks++; if ({bus.mem_en, bus.mem_we} !== 5'b0) begin errors++; $display("FAIL reset_mem_ctl: got en=%b we=%b want 0", bus.mem_en, bus.mem_we); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== 42'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata); end
    bus.cpu_req = 1'b1; bus.cpu_size = 2'b10; bus.cpu_addr = 12'h010;
    @(posedge clk); #1;
    checks++; if (bus.mem_en !== 1'b0 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_holds: got en=%b ack=%b want 0 0", bus.mem_en, bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Fill the test window with random words through the debug port.
  task automatic test_dbg_fill;
    int lat, en; logic [31:0] rd, wd, wds; logic [3:0] ws; logic [9:0] as;
    for (int w = 0; w < 32; w++) begin
      wd = $urandom;
      do_dbg(1'b1, 12'(w * 4 + int'($urandom_range(0, 3))), wd, lat, rd, en, ws, as, wds);
      checks++; if (lat !== 2 || en !== 1) begin errors++; $display("FAIL fill_lat: got lat=%0d en=%0d want 2 1", lat, en); end
      checks++; if (ws !== 4'b1111 || as !== 10'(w) || wds !== wd) begin errors++; $display("FAIL fill_bus: got we=%b addr=%0d wdata=%h want 1111 %0d %h", ws, as, wds, w, wd); end
    end
  endtask

  task automatic test_byte;
    int lat, en; logic [31:0] rd, wds; logic er; logic [3:0] ws; logic [9:0] as;
    do_cpu(1'b1, 2'b00, 1'b0, 12'h006, 32'h0000_00F5, lat, rd, er, en, ws, as, wds);
    checks++; if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL sb_ack: got lat=%0d err=%b want 2 0", lat, er); end
    checks++; if (ws !== 4'b0100 || wds !== 32'hF5F5_F5F5 || as !== 10'd1) begin errors++; $display("FAIL sb_lanes: got we=%b wdata=%h addr=%0d want 0100 f5f5f5f5 1", ws, wds, as); end
    do_cpu(1'b0, 2'b00, 1'b1, 12'h006, 32'h0, lat, rd, er, en, ws, as, wds);
    checks++; if (lat !== 3 || er !== 1'b0 || rd !== 32'hFFFF_FFF5) begin errors++; $display("FAIL lb: got lat=%0d err=%b rdata=%h want 3 0 fffffff5", lat, er, rd); end
    do_cpu(1'b0, 2'b00, 1'b0, 12'h006, 32'h0, lat, rd, er, en, ws, as, wds);
    checks++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h0000_00F5) begin errors++; $display("FAIL lbu: got lat=%0d err=%b rdata=%h want 3 0 000000f5", lat, er, rd); end
  endtask

  task automatic test_half;
    int lat, en; logic [31:0] rd, wds; logic er; logic [3:0] ws; logic [9:0] as;
    do_cpu(1'b1, 2'b01, 1'b0, 12'h00A, 32'h0000_8001, lat, rd, er, en, ws, as, wds);
    checks++; if (lat !== 2 || ws !== 4'b1100 || wds !== 32'h8001_8001) begin errors++; $display("FAIL sh: got lat=%0d we=%b wdata=%h want 2 1100 80018001", lat, ws, wds); end
    do_cpu(1'b0, 2'b01, 1'b1, 12'h00A, 32'h0, lat, rd, er, en, ws, as, wds);
    checks++; if (lat !== 3 || rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: got lat=%0d rdata=%h want 3 ffff8001", lat, rd); end
    do_cpu(1'b0, 2'b01, 1'b0, 12'h00A, 32'h0, lat, rd, er, en, ws, as, wds);
    checks++; if (lat !== 3 || rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu: got lat=%0d rdata=%h want 3 00008001", lat, rd); end
    do_dbg(1'b0, 12'h008, 32'h0, lat, rd, en, ws, as, wds);
    checks++; if (rd[31:16] !== 16'h8001 || rd !== ref_load(2'b10, 1'b0, 12'h008)) begin errors++; $display("FAIL sh_dbg_word: got %h want 8001xxxx (%h)", rd, ref_load(2'b10, 1'b0, 12'h008)); end
  endtask

  task automatic test_illegal;
    int lat, en; logic [31:0] rd, wds; logic er; logic [3:0] ws; logic [9:0] as;
    logic [1:0] sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [11:0] ad [3] = '{12'h002, 12'h003, 12'h004};
    for (int i = 0; i < 3; i++) begin
      do_cpu(1'($urandom), sz[i], 1'b0, ad[i], $urandom, lat, rd, er, en, ws, as, wds);
      checks++; if (lat !== 1 || er !== 1'b1 || en !== 0) begin errors++; $display("FAIL illegal_%0d: got lat=%0d err=%b mem_en_cycles=%0d want 1 1 0", i, lat, er, en); end
    end
  endtask

  task automatic test_debug;
    int lat, en; logic [31:0] rd, wds; logic er; logic [3:0] ws; logic [9:0] as;
    do_dbg(1'b1, 12'h013, 32'hDEAD_BEEF, lat, rd, en, ws, as, wds);
    checks++; if (lat !== 2 || as !== 10'd4 || ws !== 4'b1111 || wds !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dbg_wr: got lat=%0d addr=%0d we=%b wdata=%h want 2 4 1111 deadbeef", lat, as, ws, wds); end
    do_dbg(1'b0, 12'h010, 32'h0, lat, rd, en, ws, as, wds);
    checks++; if (lat !== 3 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dbg_rd: got lat=%0d rdata=%h want 3 deadbeef", lat, rd); end
    do_cpu(1'b0, 2'b10, 1'b1, 12'h010, 32'h0, lat, rd, er, en, ws, as, wds);
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL dbg_cpu_lw: got rdata=%h err=%b want deadbeef 0", rd, er); end
  endtask

  // Both ports request continuously; grant g goes to debug iff g % (STARVE_MAX+1) == STARVE_MAX.
  task automatic test_contention;
    int grants = 0;
    logic exp_dbg;
    bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_sext = 1'b0; bus.cpu_addr = 12'h020;
    bus.dbg_we = 1'b0; bus.dbg_addr = 12'h040;
    bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
    for (int c = 0; c < 100 && grants < 10; c++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack || bus.dbg_ack) begin
        exp_dbg = (grants % (STARVE_MAX + 1)) == STARVE_MAX;
        checks++; if ({bus.dbg_ack, bus.cpu_ack} !== {exp_dbg, !exp_dbg}) begin errors++; $display("FAIL contention_grant%0d: got dbg_ack=%b cpu_ack=%b want %b %b", grants, bus.dbg_ack, bus.cpu_ack, exp_dbg, !exp_dbg); end
        if (bus.cpu_ack && !bus.dbg_ack) begin
          checks++; if (bus.cpu_rdata !== ref_load(2'b10, 1'b0, 12'h020)) begin errors++; $display("FAIL contention_cpu_rdata: got %h want %h", bus.cpu_rdata, ref_load(2'b10, 1'b0, 12'h020)); end
        end
        if (bus.dbg_ack && !bus.cpu_ack) begin
          checks++; if (bus.dbg_rdata !== ref_load(2'b10, 1'b0, 12'h040)) begin errors++; $display("FAIL contention_dbg_rdata: got %h want %h", bus.dbg_rdata, ref_load(2'b10, 1'b0, 12'h040)); end
        end
        $display("contention grant %0d: %s", grants, bus.dbg_ack ? "dbg" : "cpu");
        grants++;
      end
    end
    checks++; if (grants !== 10) begin errors++; $display("FAIL contention_timeout: got %0d grants want 10", grants); end
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int ack_cyc [$];
    logic [31:0] exp_rd = ref_load(2'b01, 1'b1, 12'h032);
    bus.cpu_we = 1'b0; bus.cpu_size = 2'b01; bus.cpu_sext = 1'b1; bus.cpu_addr = 12'h032; bus.cpu_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) begin
        ack_cyc.push_back(c);
        checks++; if (bus.cpu_rdata !== exp_rd) begin errors++; $display("FAIL b2b_rdata: got %h want %h", bus.cpu_rdata, exp_rd); end
        if (ack_cyc.size() == 2) bus.cpu_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    checks++; if (ack_cyc.size() != 2 || ack_cyc[0] != 3 || ack_cyc[1] != 7) begin errors++; $display("FAIL b2b_timing: got %0d acks first=%0d second=%0d want 2 at 3 and 7", ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, (ack_cyc.size() > 1) ? ack_cyc[1] : -1); end
    $display("b2b lh 0x032 acks=%0d", ack_cyc.size());
  endtask

  task automatic test_random;
    int lat, en, exp_lat; logic [31:0] rd, wd, wds; logic er, exp_err, we, sext;
    logic [3:0] ws; logic [9:0] as; logic [1:0] size; logic [11:0] addr;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        addr = 12'($urandom_range(0, 127));
        wd = $urandom; we = 1'($urandom);
        do_dbg(we, addr, wd, lat, rd, en, ws, as, wds);
        checks++; if (lat !== (we ? 2 : 3) || en !== 1 || as !== addr[11:2]) begin errors++; $display("FAIL rnd_dbg_ctl: got lat=%0d en=%0d addr=%0d want %0d 1 %0d", lat, en, as, we ? 2 : 3, addr[11:2]); end
        if (!we) begin
          checks++; if (rd !== ref_load(2'b10, 1'b0, addr & 12'hFFC)) begin errors++; $display("FAIL rnd_dbg_rdata: got %h want %h", rd, ref_load(2'b10, 1'b0, addr & 12'hFFC)); end
        end
      end else begin
        size = 2'($urandom); we = 1'($urandom); sext = 1'($urandom); wd = $urandom;
        addr = 12'($urandom_range(0, 127));
        if (size != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((12'd1 << size) - 12'd1);
        exp_err = ref_err(size, addr);
        exp_lat = exp_err ? 1 : (we ? 2 : 3);
        do_cpu(we, size, sext, addr, wd, lat, rd, er, en, ws, as, wds);
        checks++; if (lat !== exp_lat || er !== exp_err || en !== (exp_err ? 0 : 1)) begin errors++; $display("FAIL rnd_cpu_ctl: got lat=%0d err=%b en=%0d want %0d %b %0d", lat, er, en, exp_lat, exp_err, exp_err ? 0 : 1); end
        if (!exp_err && we) begin
          checks++; if (ws !== exp_we(size, addr) || wds !== exp_wdata(size, wd) || as !== addr[11:2]) begin errors++; $display("FAIL rnd_store: got we=%b wdata=%h addr=%0d want %b %h %0d", ws, wds, as, exp_we(size, addr), exp_wdata(size, wd), addr[11:2]); end
        end
        if (!exp_err && !we) begin
          checks++; if (rd !== ref_load(size, sext, addr)) begin errors++; $display("FAIL rnd_load: got %h want %h", rd, ref_load(size, sext, addr)); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int lat, en, acks = 0; logic [31:0] rd, wds; logic er; logic [3:0] ws; logic [9:0] as;
    bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_sext = 1'b0; bus.cpu_addr = 12'h024; bus.cpu_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got mem_en=%b want 1", bus.mem_en); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if ({bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.mem_en, bus.mem_we} !== 8'h0) begin errors++; $display("FAIL rstmid_ctl: got ack=%b err=%b dack=%b en=%b we=%b want 0", bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.mem_en, bus.mem_we); end
    checks++; if ({bus.cpu_rdata, bus.dbg_rdata, bus.mem_addr, bus.mem_wdata} !== 106'h0) begin errors++; $display("FAIL rstmid_data: got rdata=%h drdata=%h addr=%h wdata=%h want 0", bus.cpu_rdata, bus.dbg_rdata, bus.mem_addr, bus.mem_wdata); end
    bus.cpu_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst = 1'b0;
      if (bus.cpu_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rstmid_noack: got %0d acks want 0", acks); end
    do_cpu(1'b0, 2'b10, 1'b0, 12'h024, 32'h0, lat, rd, er, en, ws, as, wds);
    checks++; if (lat !== 3 || er !== 1'b0 || rd !== ref_load(2'b10, 1'b0, 12'h024)) begin errors++; $display("FAIL rstmid_after: got lat=%0d err=%b rdata=%h want 3 0 %h", lat, er, rd, ref_load(2'b10, 1'b0, 12'h024)); end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'b00; bus.cpu_sext = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    test_reset();
    test_dbg_fill();
    test_byte();
    test_half();
    test_illegal();
    test_debug();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "watchdog");
  end

endmodule
